// File: rtl/adc128s022_responder.sv
// Device-side emulation of the DE0-Nano ADC128S022 serial link: decodes the channel
// address from DIN and returns 4 zeros plus a 12-bit sample from a parallel bus.
module adc128s022_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_W      = 12
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic                     din,
    output logic                     dout,
    output logic                     dout_oe,
    input  logic [NUM_CH*DATA_W-1:0] samples_in,
    output logic                     frame_done,
    output logic [2:0]               frame_channel,
    output logic                     frame_error
);

    localparam int unsigned FrameW = 16;

    typedef enum logic {StIdle, StActive} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, din_sync_q;
    logic                   sclk_s, cs_s, din_s;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_e                 state_q, state_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [2:0]             cur_addr_q, cur_addr_d;
    logic [2:0]             addr_shadow_q, addr_shadow_d;
    logic [FrameW-1:0]      shift_q, shift_d;
    logic                   dout_q, dout_d;
    logic                   dout_oe_q, dout_oe_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_error_q, frame_error_d;
    logic [2:0]             frame_channel_q, frame_channel_d;
    logic [DATA_W-1:0]      sample;
    int unsigned            ch_idx;

    // Synchronizers keep sampling through reset so the pin levels are valid on release.
    always_ff @(posedge sys_clk) begin
        sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    assign bit_cnt_inc = bit_cnt_q + 5'd1;
    assign ch_idx      = 32'(cur_addr_q);

    always_comb begin
        sample = '0;
        if (ch_idx < NUM_CH) begin
            sample = samples_in[ch_idx*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        cur_addr_d      = cur_addr_q;
        addr_shadow_d   = addr_shadow_q;
        shift_d         = shift_q;
        frame_done_d    = 1'b0;
        frame_error_d   = 1'b0;
        frame_channel_d = frame_channel_q;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d       = StActive;
                    bit_cnt_d     = '0;
                    cur_addr_d    = '0;
                    addr_shadow_d = '0;
                    shift_d       = '0;
                end
            end
            StActive: begin
                // A cs_n edge takes priority; any coincident sclk edge is dropped.
                if (cs_rise) begin
                    state_d       = StIdle;
                    frame_error_d = (bit_cnt_q != 5'd0);
                    bit_cnt_d     = '0;
                    addr_shadow_d = '0;
                end else if (sclk_fall) begin
                    if (bit_cnt_q == 5'd0) begin
                        shift_d = {{(FrameW-DATA_W){1'b0}}, sample};
                    end else begin
                        shift_d = shift_q << 1;
                    end
                end else if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_inc;
                    case (bit_cnt_inc)
                        5'd3:    addr_shadow_d[2] = din_s;
                        5'd4:    addr_shadow_d[1] = din_s;
                        5'd5:    addr_shadow_d[0] = din_s;
                        default: ;
                    endcase
                    if (bit_cnt_inc == 5'd16) begin
                        frame_done_d    = 1'b1;
                        frame_channel_d = cur_addr_q;
                        cur_addr_d      = addr_shadow_q;
                        bit_cnt_d       = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        dout_oe_d = (state_d == StActive);
        dout_d    = (state_q == StActive && state_d == StActive) ? shift_q[FrameW-1] : 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            // cs_prev resets low so a cs_n held low through reset never looks like a new frame.
            sclk_prev_q     <= 1'b1;
            cs_prev_q       <= 1'b0;
            state_q         <= StIdle;
            bit_cnt_q       <= '0;
            cur_addr_q      <= '0;
            addr_shadow_q   <= '0;
            shift_q         <= '0;
            dout_q          <= 1'b0;
            dout_oe_q       <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_error_q   <= 1'b0;
            frame_channel_q <= '0;
        end else begin
            sclk_prev_q     <= sclk_s;
            cs_prev_q       <= cs_s;
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            cur_addr_q      <= cur_addr_d;
            addr_shadow_q   <= addr_shadow_d;
            shift_q         <= shift_d;
            dout_q          <= dout_d;
            dout_oe_q       <= dout_oe_d;
            frame_done_q    <= frame_done_d;
            frame_error_q   <= frame_error_d;
            frame_channel_q <= frame_channel_d;
        end
    end

    assign dout          = dout_q;
    assign dout_oe       = dout_oe_q;
    assign frame_done    = frame_done_q;
    assign frame_error   = frame_error_q;
    assign frame_channel = frame_channel_q;

endmodule

// File: tb/tb_adc128s022_responder.sv
// Scoreboard bench: stimulus pushes expected frame/abort events, a monitor
// captures dout on sclk rising edges and checks each frame_done/frame_error pulse.
module tb_adc128s022_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b1;
    logic        cs_n = 1'b1;
    logic        din = 1'b0;
    logic [95:0] samples = '0;
    logic        dout, dout_oe, frame_done, frame_error;
    logic [2:0]  frame_channel;

    adc128s022_responder #(
        .SYNC_STAGES(2),
        .NUM_CH     (8),
        .DATA_W     (12)
    ) dut (
        .sys_clk      (clk),
        .reset        (rst),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .din          (din),
        .dout         (dout),
        .dout_oe      (dout_oe),
        .samples_in   (samples),
        .frame_done   (frame_done),
        .frame_channel(frame_channel),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [15:0] bits;
        logic [2:0]  ch;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] cap = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic set_ch(input int ch, input logic [11:0] v);
        samples[ch*12 +: 12] = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_done(input logic [2:0] ch, input logic [11:0] word);
        exp_q.push_back('{1'b0, {4'h0, word}, ch});
    endtask

    task automatic push_err();
        exp_q.push_back('{1'b1, 16'h0, 3'h0});
    endtask

    // Non-address din bits are driven high so ignoring them is exercised.
    task automatic run_edges(input logic [2:0] addr, input int n_rise, input int chg_at,
                             input int chg_ch, input logic [11:0] chg_val);
        for (int i = 1; i <= n_rise; i++) begin
            sclk = 1'b0;
            case (i)
                3:       din = addr[2];
                4:       din = addr[1];
                5:       din = addr[0];
                default: din = 1'b1;
            endcase
            tick(HALF);
            sclk = 1'b1;
            tick(HALF);
            if (i == chg_at) set_ch(chg_ch, chg_val);
        end
    endtask

    task automatic frame(input logic [2:0] addr, input logic [2:0] ch, input logic [11:0] word);
        push_done(ch, word);
        run_edges(addr, 16, 0, 0, 12'h000);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        tick(HALF);
    endtask

    initial forever begin
        @(posedge sclk);
        if (!cs_n && dout_oe) cap = {cap[14:0], dout};
    end

    initial forever begin
        @(negedge clk);
        if (frame_done || frame_error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({frame_done, frame_error}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_is_error", 32'(frame_error), 32'(mon_e.err));
                check("event_is_done", 32'(frame_done), 32'(!mon_e.err));
                if (!mon_e.err) begin
                    check("frame_word", 32'(cap), 32'(mon_e.bits));
                    check("frame_channel", 32'(frame_channel), 32'(mon_e.ch));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] idle_acc;
        set_ch(0, 12'hA5C); set_ch(1, 12'h111); set_ch(2, 12'h3C1); set_ch(3, 12'h123);
        set_ch(4, 12'h444); set_ch(5, 12'h7FF); set_ch(6, 12'h666); set_ch(7, 12'h777);

        // Reset and idle with cs_n high
        rst = 1'b1;
        tick(5);
        check("rst_dout_oe", 32'(dout_oe), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_frame_channel", 32'(frame_channel), 32'd0);
        rst = 1'b0;
        idle_acc = '0;
        repeat (100) begin
            @(negedge clk);
            idle_acc = idle_acc | {dout_oe, dout, frame_done, frame_error};
        end
        check("idle_quiet", 32'(idle_acc), 32'd0);

        // Three back-to-back frames: address of frame N selects sample of frame N+1
        cs_low();
        check("active_dout_oe", 32'(dout_oe), 32'd1);
        check("active_dout", 32'(dout), 32'd0);
        frame(3'b101, 3'd0, 12'hA5C);
        frame(3'b010, 3'd5, 12'h7FF);
        frame(3'b011, 3'd2, 12'h3C1);
        cs_high();
        check("end_dout_oe", 32'(dout_oe), 32'd0);

        // Aborted frame after 9 rising edges
        cs_low();
        push_err();
        run_edges(3'b110, 9, 0, 0, 12'h000);
        cs_high();
        check("abort_dout_oe", 32'(dout_oe), 32'd0);
        check("abort_dout", 32'(dout), 32'd0);

        // First frame after abort is channel 0; then ch3 changes mid-frame
        cs_low();
        frame(3'b011, 3'd0, 12'hA5C);
        push_done(3'd3, 12'h123);
        run_edges(3'b011, 16, 8, 3, 12'hFFF);
        frame(3'b001, 3'd3, 12'hFFF);
        cs_high();

        // Reset during bit 6 with cs_n held low
        cs_low();
        run_edges(3'b101, 6, 0, 0, 12'h000);
        rst = 1'b1;
        tick(1);
        check("midrst_dout_oe", 32'(dout_oe), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_frame_channel", 32'(frame_channel), 32'd0);
        rst = 1'b0;
        run_edges(3'b111, 10, 0, 0, 12'h000);
        check("postrst_dout_oe", 32'(dout_oe), 32'd0);
        cs_high();
        cs_low();
        check("rearm_dout_oe", 32'(dout_oe), 32'd1);
        frame(3'b000, 3'd0, 12'hA5C);
        cs_high();

        tick(20);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
